// File: rtl/dbg_pkg.sv
// Shared types and sizing helpers for the debug telemetry streamer.
// Frame layout: SYNC, seq, channel bytes, checksum.
package dbg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_GUARD,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [7:0] DEF_SYNC = 8'hA5;

    function automatic int bytes_of(input int w);
        return (w + 7) / 8;
    endfunction

    function automatic int frame_len(input int n, input int w);
        return 3 + n * bytes_of(w);
    endfunction

endpackage

// File: rtl/dbg_period_timer.sv
// Free-running frame timer: one-cycle tick every PERIOD cycles.
// Held at zero while disabled; PERIOD=0 removes the timer entirely.
module dbg_period_timer #(
    parameter int PERIOD = 10000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    generate
        if (PERIOD == 0) begin : g_off
            assign tick = 1'b0;
        end else begin : g_on
            localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
            localparam logic [CW-1:0] TOP = CW'(PERIOD - 1);

            logic [CW-1:0] cnt;

            assign tick = enable && (cnt == TOP);

            always_ff @(posedge clk) begin
                if (rst || !enable) begin
                    cnt <= '0;
                end else if (cnt == TOP) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/dbg_uart_streamer.sv
// Snapshots N_CH channels and streams them as a checksummed frame
// into the uart_tx byte interface, one byte per busy-free slot.
module dbg_uart_streamer
    import dbg_pkg::*;
#(
    parameter int         N_CH      = 2,
    parameter int         WORD_W    = 32,
    parameter int         PERIOD    = 10000,
    parameter bit         MSB_FIRST = 1'b0,
    parameter logic [7:0] SYNC      = DEF_SYNC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   trigger,
    input  logic [N_CH*WORD_W-1:0] ch_data,
    input  logic                   tx_busy,
    output logic                   tx_en,
    output logic [7:0]             tx_data,
    output logic                   active,
    output logic                   frame_done,
    output logic                   overrun,
    output logic [7:0]             seq
);

    localparam int BYTES = bytes_of(WORD_W);
    localparam int NB    = N_CH * BYTES;
    localparam int FLEN  = frame_len(N_CH, WORD_W);
    localparam int IW    = $clog2(FLEN);
    localparam logic [IW-1:0] LAST = IW'(FLEN - 1);

    state_t            state;
    state_t            state_n;
    logic [IW-1:0]     idx;
    logic [7:0]        acc;
    logic [7:0]        cur;
    logic [7:0]        snap   [NB];
    logic [7:0]        snap_n [NB];
    logic [BYTES*8-1:0] pad_w;
    logic              tick;
    logic              req;

    dbg_period_timer #(
        .PERIOD(PERIOD)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .enable(enable),
        .tick  (tick)
    );

    assign req    = tick | (trigger & enable);
    assign active = (state != S_IDLE);

    // Snapshot stored already in wire order, pad bits zeroed.
    always_comb begin
        pad_w = '0;
        for (int i = 0; i < NB; i++) snap_n[i] = '0;
        for (int c = 0; c < N_CH; c++) begin
            pad_w = '0;
            pad_w[WORD_W-1:0] = ch_data[c*WORD_W +: WORD_W];
            for (int b = 0; b < BYTES; b++) begin
                snap_n[c*BYTES+b] = MSB_FIRST ?
                    pad_w[(BYTES-1-b)*8 +: 8] : pad_w[b*8 +: 8];
            end
        end
    end

    always_comb begin
        cur = '0;
        unique case (1'b1)
            (idx == '0):     cur = SYNC;
            (idx == IW'(1)): cur = seq;
            (idx == LAST):   cur = 8'h00 - acc;
            default: begin
                for (int k = 0; k < NB; k++) begin
                    if (idx == IW'(k + 2)) cur = snap[k];
                end
            end
        endcase
    end

    always_comb begin
        state_n    = state;
        tx_en      = 1'b0;
        tx_data    = '0;
        frame_done = 1'b0;
        unique case (state)
            S_IDLE:  if (req) state_n = S_SEND;
            S_SEND: begin
                if (!tx_busy) begin
                    tx_en   = 1'b1;
                    tx_data = cur;
                    state_n = S_GUARD;
                end
            end
            S_GUARD: state_n = S_WAIT;
            S_WAIT: begin
                if (!tx_busy) state_n = (idx == LAST) ? S_DONE : S_SEND;
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_n    = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            idx     <= '0;
            acc     <= '0;
            seq     <= '0;
            overrun <= 1'b0;
        end else begin
            state <= state_n;
            if (state == S_IDLE && req) begin
                idx <= '0;
                acc <= '0;
            end
            if (active && req) overrun <= 1'b1;
            // SYNC stays out of the checksum.
            if (tx_en && idx != '0) acc <= acc + cur;
            if (state == S_WAIT && !tx_busy && idx != LAST) begin
                idx <= idx + IW'(1);
            end
            if (state == S_DONE) seq <= seq + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && req) snap <= snap_n;
    end

endmodule

// File: tb/tb_dbg_uart_streamer.sv
// Bench for dbg_uart_streamer: four configurations, uart_tx busy models,
// frame reference model, table vectors, random frames, timer/overrun/reset.
module tb_dbg_uart_streamer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  enable_v  = 4'b0000;
    logic [3:0]  trigger_v = 4'b0000;
    logic [3:0]  busy_v;
    logic [3:0]  tx_en_v;
    logic [3:0]  act_v;
    logic [3:0]  done_v;
    logic [3:0]  ovr_v;
    logic [7:0]  txd  [4];
    logic [7:0]  seqo [4];
    logic [63:0] ch_ab = '0;
    logic [11:0] ch_d  = '0;

    int pass_n  = 0;
    int total_n = 0;
    int cyc     = 0;

    logic [7:0] cap     [4][1024];
    int         cap_cyc [4][1024];
    int         ncap  [4] = '{default: 0};
    int         ndone [4] = '{default: 0};
    int         viol  [4] = '{default: 0};
    logic [3:0] pend      = '0;
    int         bcnt  [4] = '{default: 0};

    logic [7:0] exp_q [$];
    logic [7:0] seq_m [4] = '{default: 8'd0};

    typedef struct {
        int          g;
        logic [63:0] c0;
        logic [63:0] c1;
        logic [7:0]  csum;
    } vec_t;
    vec_t vt [3];

    // A: LE 32b, B: BE 32b, C: timer PERIOD=50, D: 1 x 12b.
    dbg_uart_streamer #(.N_CH(2), .WORD_W(32), .PERIOD(0), .MSB_FIRST(0)) u_a (
        .clk(clk), .rst(rst), .enable(enable_v[0]), .trigger(trigger_v[0]),
        .ch_data(ch_ab), .tx_busy(busy_v[0]), .tx_en(tx_en_v[0]),
        .tx_data(txd[0]), .active(act_v[0]), .frame_done(done_v[0]),
        .overrun(ovr_v[0]), .seq(seqo[0]));
    dbg_uart_streamer #(.N_CH(2), .WORD_W(32), .PERIOD(0), .MSB_FIRST(1)) u_b (
        .clk(clk), .rst(rst), .enable(enable_v[1]), .trigger(trigger_v[1]),
        .ch_data(ch_ab), .tx_busy(busy_v[1]), .tx_en(tx_en_v[1]),
        .tx_data(txd[1]), .active(act_v[1]), .frame_done(done_v[1]),
        .overrun(ovr_v[1]), .seq(seqo[1]));
    dbg_uart_streamer #(.N_CH(2), .WORD_W(32), .PERIOD(50), .MSB_FIRST(0)) u_c (
        .clk(clk), .rst(rst), .enable(enable_v[2]), .trigger(trigger_v[2]),
        .ch_data(ch_ab), .tx_busy(busy_v[2]), .tx_en(tx_en_v[2]),
        .tx_data(txd[2]), .active(act_v[2]), .frame_done(done_v[2]),
        .overrun(ovr_v[2]), .seq(seqo[2]));
    dbg_uart_streamer #(.N_CH(1), .WORD_W(12), .PERIOD(0), .MSB_FIRST(0)) u_d (
        .clk(clk), .rst(rst), .enable(enable_v[3]), .trigger(trigger_v[3]),
        .ch_data(ch_d), .tx_busy(busy_v[3]), .tx_en(tx_en_v[3]),
        .tx_data(txd[3]), .active(act_v[3]), .frame_done(done_v[3]),
        .overrun(ovr_v[3]), .seq(seqo[3]));

    function automatic int blen(input int g);
        if (g < 2) return 10;
        if (g == 2) return 1;
        return 3;
    endfunction

    function automatic int flen(input int g);
        return (g == 3) ? 5 : 11;
    endfunction

    // uart_tx model: busy rises one cycle after the accepted byte.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int g = 0; g < 4; g++) begin
            if (tx_en_v[g]) pend[g] <= 1'b1;
            if (pend[g]) begin
                bcnt[g] <= blen(g);
                pend[g] <= 1'b0;
            end else if (bcnt[g] > 0) begin
                bcnt[g] <= bcnt[g] - 1;
            end
        end
    end

    always_comb begin
        busy_v = '0;
        for (int g = 0; g < 4; g++) busy_v[g] = (bcnt[g] != 0);
    end

    always @(negedge clk) begin
        for (int g = 0; g < 4; g++) begin
            if (tx_en_v[g]) begin
                if (ncap[g] < 1024) begin
                    cap[g][ncap[g]]     <= txd[g];
                    cap_cyc[g][ncap[g]] <= cyc;
                end
                ncap[g] <= ncap[g] + 1;
                if (busy_v[g]) viol[g] <= viol[g] + 1;
            end
            if (done_v[g]) ndone[g] <= ndone[g] + 1;
        end
    end

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] req);
        total_n++;
        if (act === req) pass_n++;
        else $display("FAIL %s: got %0h want %0h", nm, act, req);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic make_frame(input int g, input logic [63:0] c0,
                              input logic [63:0] c1, input logic [7:0] s);
        int nch;
        int wb;
        int nb;
        int sum;
        bit msb;
        logic [63:0] w;
        nch = (g == 3) ? 1 : 2;
        wb  = (g == 3) ? 12 : 32;
        msb = (g == 1);
        nb  = (wb + 7) / 8;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(s);
        sum = int'(s);
        for (int c = 0; c < nch; c++) begin
            w = ((c == 0) ? c0 : c1) & ((64'd1 << wb) - 64'd1);
            for (int b = 0; b < nb; b++) begin
                int sh;
                logic [7:0] by;
                sh  = msb ? (nb - 1 - b) : b;
                by  = 8'(w >> (8 * sh));
                exp_q.push_back(by);
                sum += int'(by);
            end
        end
        exp_q.push_back(8'((256 - (sum % 256)) % 256));
    endtask

    task automatic compare_frame(input int g, input int base);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < 1024)
                check($sformatf("g%0d byte%0d", g, i),
                      cap[g][base+i], exp_q[i]);
        end
    endtask

    task automatic wait_done(input int g, input int n0, input string nm);
        int k;
        k = 0;
        while (ndone[g] <= n0 && k < 3000) begin
            @(posedge clk);
            k++;
        end
        #1;
        check({nm, " done"}, 64'(ndone[g] > n0), 64'd1);
    endtask

    task automatic wait_bytes(input int g, input int n, input string nm);
        int k;
        k = 0;
        while (ncap[g] < n && k < 3000) begin
            step(1);
            k++;
        end
        check({nm, " bytes"}, 64'(ncap[g] >= n), 64'd1);
    endtask

    task automatic run_frame(input int g, input logic [63:0] c0,
                             input logic [63:0] c1, output int base);
        int n0;
        int c;
        if (g == 3) ch_d = c0[11:0];
        else ch_ab = {c1[31:0], c0[31:0]};
        base = ncap[g];
        n0   = ndone[g];
        make_frame(g, c0, c1, seq_m[g]);
        c = cyc;
        trigger_v[g] = 1'b1;
        step(1);
        trigger_v[g] = 1'b0;
        check($sformatf("g%0d active", g), act_v[g], 1'b1);
        wait_done(g, n0, $sformatf("g%0d frame", g));
        check($sformatf("g%0d len", g), ncap[g] - base, exp_q.size());
        compare_frame(g, base);
        check($sformatf("g%0d latency", g), cap_cyc[g][base], c + 1);
        check($sformatf("g%0d seq", g), seqo[g], seq_m[g] + 8'd1);
        check($sformatf("g%0d done once", g), ndone[g] - n0, 1);
        check($sformatf("g%0d idle", g), act_v[g], 1'b0);
        check($sformatf("g%0d no ovr", g), ovr_v[g], 1'b0);
        seq_m[g] = seq_m[g] + 8'd1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int base;
        int n0;
        int c;
        int g;
        vt[0] = '{0, 64'h12345678, 64'hCAFEBABE, 8'hAC};
        vt[1] = '{1, 64'h12345678, 64'hCAFEBABE, 8'hAC};
        vt[2] = '{3, 64'h0ABC, 64'h0, 8'h3A};

        step(3);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst g%0d tx_en", i), tx_en_v[i], 1'b0);
            check($sformatf("rst g%0d tx_data", i), txd[i], 8'h00);
            check($sformatf("rst g%0d active", i), act_v[i], 1'b0);
            check($sformatf("rst g%0d done", i), done_v[i], 1'b0);
            check($sformatf("rst g%0d ovr", i), ovr_v[i], 1'b0);
            check($sformatf("rst g%0d seq", i), seqo[i], 8'h00);
        end
        rst = 1'b0;
        enable_v = 4'b1011;
        step(2);

        for (int i = 0; i < 3; i++) begin
            run_frame(vt[i].g, vt[i].c0, vt[i].c1, base);
            check($sformatf("vec%0d csum", i),
                  cap[vt[i].g][base + flen(vt[i].g) - 1], vt[i].csum);
        end

        for (int i = 0; i < 6; i++) begin
            g = $urandom_range(0, 2);
            if (g == 2) g = 3;
            run_frame(g, {$urandom, $urandom}, {$urandom, $urandom}, base);
        end

        ch_ab = 64'h0BAD_F00D_1357_9BDF;
        base = ncap[2];
        n0 = ndone[2];
        c = cyc;
        enable_v[2] = 1'b1;
        begin
            int k;
            k = 0;
            while (ndone[2] < n0 + 3 && k < 1000) begin
                step(1);
                k++;
            end
        end
        check("timer 3 frames", ndone[2] - n0, 3);
        check("timer bytes", ncap[2] - base, 33);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("timer start%0d", k),
                  cap_cyc[2][base + 11*k], c + 50 + 50*k);
            make_frame(2, {32'h0, ch_ab[31:0]}, {32'h0, ch_ab[63:32]}, 8'(k));
            compare_frame(2, base + 11*k);
        end
        enable_v[2] = 1'b0;
        step(20);
        base = ncap[2];
        step(200);
        check("timer off", ncap[2] - base, 0);
        check("timer off ovr", ovr_v[2], 1'b0);
        n0 = ndone[2];
        c = cyc;
        enable_v[2] = 1'b1;
        wait_bytes(2, base + 1, "timer restart");
        check("timer restart start", cap_cyc[2][base], c + 50);
        enable_v[2] = 1'b0;
        wait_done(2, n0, "timer last");
        make_frame(2, {32'h0, ch_ab[31:0]}, {32'h0, ch_ab[63:32]}, 8'd3);
        compare_frame(2, base);
        check("timer seq", seqo[2], 8'd4);

        ch_ab = 64'h0102_0304_F0E0_D0C0;
        base = ncap[0];
        n0 = ndone[0];
        make_frame(0, 64'hF0E0_D0C0, 64'h0102_0304, seq_m[0]);
        trigger_v[0] = 1'b1;
        step(1);
        trigger_v[0] = 1'b0;
        wait_bytes(0, base + 3, "ovr");
        trigger_v[0] = 1'b1;
        ch_ab = ~ch_ab;
        step(1);
        trigger_v[0] = 1'b0;
        check("ovr set", ovr_v[0], 1'b1);
        wait_done(0, n0, "ovr frame");
        check("ovr len", ncap[0] - base, 11);
        compare_frame(0, base);
        seq_m[0] = seq_m[0] + 8'd1;
        base = ncap[0];
        step(300);
        check("ovr no extra", ncap[0] - base, 0);
        check("ovr sticky", ovr_v[0], 1'b1);

        base = ncap[0];
        trigger_v[0] = 1'b1;
        step(1);
        trigger_v[0] = 1'b0;
        wait_bytes(0, base + 4, "rst mid");
        rst = 1'b1;
        step(1);
        check("rst mid tx_en", tx_en_v[0], 1'b0);
        check("rst mid active", act_v[0], 1'b0);
        check("rst mid seq", seqo[0], 8'h00);
        check("rst mid ovr", ovr_v[0], 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) seq_m[i] = 8'd0;
        base = ncap[0];
        step(60);
        check("rst mid quiet", ncap[0] - base, 0);
        run_frame(0, 64'h8765_4321, 64'h0F1E_2D3C, base);

        for (int i = 0; i < 4; i++)
            check($sformatf("g%0d busy respected", i), viol[i], 0);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
